// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and defaults for the multi-core DRAM port arbiter.
// State and op encodings are used by the arbiter and visible to anything that imports the package.
package dram_port_arbiter_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int N_CORES_DEF    = 4;
  localparam int READ_LAT_DEF   = 2;

  // Read-latency countdown holds READ_LAT-1, and READ_LAT is at most 4.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Core-request and DRAM-port bundle of the arbiter.
// The arbiter uses the slave view; the cores plus the DRAM use the master view.
interface dram_port_arbiter_if
  import dram_port_arbiter_pkg::*;
#(
  parameter int N_CORES    = N_CORES_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic [N_CORES-1:0]            req_read;
  logic [N_CORES-1:0]            req_write;
  logic [N_CORES*ADDR_WIDTH-1:0] req_addr;
  logic [N_CORES*WIDTH-1:0]      req_wdata;
  logic [N_CORES-1:0]            ack;
  logic [WIDTH-1:0]              rdata;
  logic [ADDR_WIDTH-1:0]         dram_addr;
  logic [WIDTH-1:0]              dram_wdata;
  logic                          dram_we;
  logic                          dram_re;
  logic [WIDTH-1:0]              dram_rdata;
  logic                          busy;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, dram_rdata,
    output ack, rdata, dram_addr, dram_wdata, dram_we, dram_re, busy
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, dram_rdata,
    input  ack, rdata, dram_addr, dram_wdata, dram_we, dram_re, busy
  );

endinterface

// File: rtl/dram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index above last_grant, with wrap-around.
module rr_picker
  import dram_port_arbiter_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  localparam int IDW    = id_width(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  // cand_idx[k] is the core with the k-th highest priority this round.
  logic [IDW-1:0] cand_idx [N_CORES];

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_cand
      assign cand_idx[gi] = IDW'((int'(last_grant) + gi + 1) % N_CORES);
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) grant_idx = cand_idx[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between N_CORES requesting cores.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK -> IDLE.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int N_CORES    = N_CORES_DEF,
  parameter int READ_LAT   = READ_LAT_DEF
) (
  input logic                Clk,
  input logic                Rst,
  dram_port_arbiter_if.slave bus
);

  localparam int IDW = id_width(N_CORES);

  arb_state_t             state_reg, state_next;
  arb_op_t                op_reg;
  logic [IDW-1:0]         winner_reg;
  logic [IDW-1:0]         last_grant_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]       wdata_reg;
  logic [WIDTH-1:0]       rdata_reg;
  logic [CNT_W-1:0]       cnt_reg;

  logic [N_CORES-1:0]     active;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_any;
  logic [ADDR_WIDTH-1:0]  addr_arr  [N_CORES];
  logic [WIDTH-1:0]       wdata_arr [N_CORES];

  assign active = bus.req_read | bus.req_write;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
      // Gated by Rst so a reset cycle never acks an aborted transaction.
      assign bus.ack[gi] = !Rst && (state_reg == ARB_ACK) && (winner_reg == IDW'(gi));
    end
  endgenerate

  rr_picker #(.N_CORES(N_CORES)) u_picker (
    .req        (active),
    .last_grant (last_grant_reg),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= ARB_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:  if (pick_any) state_next = ARB_ISSUE;
      ARB_ISSUE: state_next = (op_reg == OP_WR) ? ARB_ACK : ARB_WAIT;
      ARB_WAIT:  if (cnt_reg == '0) state_next = ARB_ACK;
      ARB_ACK:   state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_reg         <= OP_RD;
      winner_reg     <= '0;
      last_grant_reg <= IDW'(N_CORES - 1);
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            winner_reg <= pick_idx;
            addr_reg   <= addr_arr[pick_idx];
            wdata_reg  <= wdata_arr[pick_idx];
            op_reg     <= bus.req_write[pick_idx] ? OP_WR : OP_RD;
          end
        end
        ARB_ISSUE: cnt_reg <= CNT_W'(READ_LAT - 1);
        ARB_WAIT: begin
          // cnt==0 marks the cycle the RAM presents data for our dram_re.
          if (cnt_reg == '0) rdata_reg <= bus.dram_rdata;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        ARB_ACK: last_grant_reg <= winner_reg;
        default: ;
      endcase
    end
  end

  assign bus.dram_addr  = addr_reg;
  assign bus.dram_wdata = wdata_reg;
  assign bus.dram_we    = !Rst && (state_reg == ARB_ISSUE) && (op_reg == OP_WR);
  assign bus.dram_re    = !Rst && (state_reg == ARB_ISSUE) && (op_reg == OP_RD);
  assign bus.rdata      = rdata_reg;
  assign bus.busy       = (state_reg != ARB_IDLE);

endmodule
